// File: rtl/dg_stack_pkg.sv
// Shared constants for the return-address stack family: overflow policies and
// the derivation of the level-output width.
package dg_stack_pkg;

  localparam int unsigned OVF_DISCARD = 0;
  localparam int unsigned OVF_REJECT  = 1;

  // Enough bits to hold 0..depth inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x ADDR_W register array: one synchronous write port and two
// combinational read ports (top and peek), addressed by physical slot.
module call_stack_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  top_ptr,
  output logic [ADDR_W-1:0] top_data,
  input  logic [PTR_W-1:0]  peek_ptr,
  output logic [ADDR_W-1:0] peek_data
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign top_data  = mem_q[top_ptr];
  assign peek_data = mem_q[peek_ptr];

endmodule

// File: rtl/call_stack_param.sv
// Parametrised return-address stack: level counter, sticky error flags and
// overflow policy around a circular buffer held in call_stack_mem.
module call_stack_param
  import dg_stack_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned OVF_MODE = OVF_DISCARD,
  parameter int unsigned LVL_W    = lvl_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       clr_err,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          top_addr,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [LVL_W-1:0]           level,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam bit Reject = (OVF_MODE == OVF_REJECT);

  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  base_q, base_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              set_ovf, set_unf;
  logic              is_empty, is_full;
  logic              we;
  logic [PTR_W-1:0]  wr_ptr, top_ptr, peek_ptr;
  logic [ADDR_W-1:0] top_data, peek_data;

  function automatic logic [PTR_W-1:0] wrap(input int unsigned v);
    return PTR_W'(v % DEPTH);
  endfunction

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LVL_W'(DEPTH));

  // base_q is the physical slot of the oldest entry; logical slot p lives at base+p.
  always_comb begin
    int unsigned b, l;
    b        = 32'(base_q);
    l        = 32'(level_q);
    top_ptr  = wrap(b + l + DEPTH - 1);
    peek_ptr = wrap(b + l + DEPTH - 1 - 32'(rd_idx));
  end

  always_comb begin
    level_d = level_q;
    base_d  = base_q;
    we      = 1'b0;
    wr_ptr  = wrap(32'(base_q) + 32'(level_q));
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (ena) begin
      if (push && !pop) begin
        if (!is_full) begin
          we      = 1'b1;
          level_d = level_q + LVL_W'(1);
        end else begin
          set_ovf = 1'b1;
          if (!Reject) begin
            // Oldest slot is overwritten and becomes the new top.
            we     = 1'b1;
            wr_ptr = base_q;
            base_d = wrap(32'(base_q) + 1);
          end
        end
      end else if (pop && !push) begin
        if (is_empty) begin
          set_unf = 1'b1;
        end else begin
          level_d = level_q - LVL_W'(1);
        end
      end else if (push && pop) begin
        we = 1'b1;
        if (is_empty) begin
          level_d = LVL_W'(1);
          set_unf = 1'b1;
        end else begin
          wr_ptr = top_ptr;
        end
      end
    end

    ovf_d = ovf_q;
    unf_d = unf_q;
    if (ena && clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (set_ovf) ovf_d = 1'b1;
    if (set_unf) unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      base_q  <= base_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  call_stack_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr_ptr    (wr_ptr),
    .wr_data   (push_addr),
    .top_ptr   (top_ptr),
    .top_data  (top_data),
    .peek_ptr  (peek_ptr),
    .peek_data (peek_data)
  );

  assign top_addr  = is_empty ? '0 : top_data;
  assign rd_addr   = (LVL_W'(rd_idx) < level_q) ? peek_data : '0;
  assign level     = level_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack_param.sv
// Drives a discard-mode and a reject-mode stack with identical stimulus and
// compares both against queue-based reference models.
module tb_call_stack_param;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, ena, push, pop, clr_err;
  logic [9:0] push_addr;
  logic [1:0] rd_idx;

  logic [9:0] top_addr [2];
  logic [9:0] rd_addr  [2];
  logic [2:0] level    [2];
  logic       empty    [2];
  logic       full     [2];
  logic       overflow [2];
  logic       underflow[2];

  int errors = 0;
  int checks = 0;

  // Reference state: index 0 of each queue is the oldest entry.
  logic [9:0] stk0[$];
  logic [9:0] stk1[$];
  bit         m_ovf[2];
  bit         m_unf[2];

  always #5 clk = ~clk;

  call_stack_param #(.ADDR_W(10), .DEPTH(DEPTH), .OVF_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .ena(ena), .push(push), .pop(pop), .push_addr(push_addr),
    .clr_err(clr_err), .rd_idx(rd_idx), .top_addr(top_addr[0]), .rd_addr(rd_addr[0]),
    .level(level[0]), .empty(empty[0]), .full(full[0]), .overflow(overflow[0]),
    .underflow(underflow[0])
  );

  call_stack_param #(.ADDR_W(10), .DEPTH(DEPTH), .OVF_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena), .push(push), .pop(pop), .push_addr(push_addr),
    .clr_err(clr_err), .rd_idx(rd_idx), .top_addr(top_addr[1]), .rd_addr(rd_addr[1]),
    .level(level[1]), .empty(empty[1]), .full(full[1]), .overflow(overflow[1]),
    .underflow(underflow[1])
  );

  task automatic chk(input string tag, input int m, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  function automatic int msize(input int m);
    return (m == 0) ? stk0.size() : stk1.size();
  endfunction

  function automatic logic [9:0] exp_peek(input int m, input int i);
    int n;
    n = msize(m);
    if (i >= n) return 10'h0;
    return (m == 0) ? stk0[n-1-i] : stk1[n-1-i];
  endfunction

  task automatic model_step(input int m, input bit en, input bit pu, input bit po,
                            input logic [9:0] ad, input bit ce);
    logic [9:0] q[$];
    bit so, su;
    so = 0;
    su = 0;
    q = (m == 0) ? stk0 : stk1;
    if (en) begin
      if (pu && !po) begin
        if (q.size() < DEPTH) q.push_back(ad);
        else begin
          so = 1;
          if (m == 0) begin
            q.delete(0);
            q.push_back(ad);
          end
        end
      end else if (po && !pu) begin
        if (q.size() > 0) q.delete(q.size() - 1);
        else su = 1;
      end else if (pu && po) begin
        if (q.size() > 0) q[q.size() - 1] = ad;
        else begin
          q.push_back(ad);
          su = 1;
        end
      end
      if (ce) begin
        m_ovf[m] = 0;
        m_unf[m] = 0;
      end
      if (so) m_ovf[m] = 1;
      if (su) m_unf[m] = 1;
    end
    if (m == 0) stk0 = q;
    else stk1 = q;
  endtask

  task automatic model_reset();
    stk0.delete();
    stk1.delete();
    m_ovf = '{0, 0};
    m_unf = '{0, 0};
  endtask

  // Takes 4 time units: scalar outputs first, then every peek index.
  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      int n;
      n = msize(m);
      chk({tag, ":level"}, m, level[m], n);
      chk({tag, ":top"}, m, top_addr[m], exp_peek(m, 0));
      chk({tag, ":empty"}, m, empty[m], (n == 0));
      chk({tag, ":full"}, m, full[m], (n == DEPTH));
      chk({tag, ":ovf"}, m, overflow[m], m_ovf[m]);
      chk({tag, ":unf"}, m, underflow[m], m_unf[m]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 2'(i);
      #1;
      for (int m = 0; m < 2; m++) chk({tag, ":peek"}, m, rd_addr[m], exp_peek(m, i));
    end
  endtask

  task automatic cyc(input string tag, input bit en, input bit pu, input bit po,
                     input logic [9:0] ad, input bit ce);
    ena = en; push = pu; pop = po; push_addr = ad; clr_err = ce;
    @(posedge clk);
    model_step(0, en, pu, po, ad, ce);
    model_step(1, en, pu, po, ad, ce);
    #1;
    ena = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic peek_const(input string tag, input int i, input logic [9:0] e0,
                            input logic [9:0] e1);
    rd_idx = 2'(i);
    #1;
    chk(tag, 0, rd_addr[0], e0);
    chk(tag, 1, rd_addr[1], e1);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    push_addr = '0; rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Basic push/pop with peek.
    cyc("p101", 1, 1, 0, 10'h101, 0);
    cyc("p202", 1, 1, 0, 10'h202, 0);
    cyc("p303", 1, 1, 0, 10'h303, 0);
    chk("tp1_top", 0, top_addr[0], 10'h303);
    peek_const("tp1_idx2", 2, 10'h101, 10'h101);
    cyc("pop1", 1, 0, 1, 10'h0, 0);
    chk("tp1_pop1", 0, top_addr[0], 10'h202);
    cyc("pop2", 1, 0, 1, 10'h0, 0);
    cyc("pop3", 1, 0, 1, 10'h0, 0);
    chk("tp1_empty_top", 1, top_addr[1], 10'h0);

    // Overflow policies: dut0 discards oldest, dut1 rejects.
    for (int k = 1; k <= 5; k++) cyc("ovfpush", 1, 1, 0, 10'(k), 0);
    chk("ovf_full0", 0, full[0], 1'b1);
    chk("ovf_flag1", 1, overflow[1], 1'b1);
    for (int i = 0; i < DEPTH; i++)
      peek_const("ovf_peek", i, 10'(5 - i), 10'(4 - i));
    cyc("clr", 1, 0, 0, 10'h0, 1);
    chk("clr_ovf", 1, overflow[1], 1'b0);

    // Underflow, replace on empty, clear colliding with a set.
    for (int k = 0; k < 4; k++) cyc("drain", 1, 0, 1, 10'h0, 0);
    cyc("unf_pop", 1, 0, 1, 10'h0, 0);
    chk("unf_set", 0, underflow[0], 1'b1);
    cyc("rep_empty", 1, 1, 1, 10'h3FF, 0);
    chk("rep_empty_top", 0, top_addr[0], 10'h3FF);
    cyc("pop_last", 1, 0, 1, 10'h0, 0);
    cyc("clr_vs_unf", 1, 0, 1, 10'h0, 1);
    chk("set_wins", 1, underflow[1], 1'b1);

    // Replace-top at level 2, then ena low must freeze everything.
    cyc("p010", 1, 1, 0, 10'h010, 0);
    cyc("p020", 1, 1, 0, 10'h020, 0);
    cyc("rep0AA", 1, 1, 1, 10'h0AA, 0);
    chk("rep_top", 0, top_addr[0], 10'h0AA);
    peek_const("rep_idx1", 1, 10'h010, 10'h010);
    for (int k = 0; k < 5; k++) cyc("ena_low", 0, 1, k[0], 10'(k + 10'h155), 1);

    // Asynchronous reset between edges.
    cyc("p111", 1, 1, 0, 10'h111, 0);
    cyc("p222", 1, 1, 0, 10'h222, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_level", 0, level[0], 0);
    chk("arst_unf", 1, underflow[1], 1'b0);
    check_all("arst");
    #1;
    rst = 1'b0;
    cyc("p333", 1, 1, 0, 10'h333, 0);
    chk("post_rst_top", 1, top_addr[1], 10'h333);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      bit en, pu, po, ce;
      en = ($urandom_range(0, 7) != 0);
      pu = ($urandom_range(0, 1) == 1);
      po = ($urandom_range(0, 2) == 0);
      ce = ($urandom_range(0, 15) == 0);
      cyc("rand", en, pu, po, 10'($urandom), ce);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
